sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 115 +++++++++++
 tb/tb_sdram_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - arbitrates init/refresh/write/read access to one SDRAM command bus
module sdram_arbiter #(
   parameter int         ADDR_WIDTH = 12,
   parameter int         TIMEOUT    = 1023,
   parameter logic [3:0] CMD_NOP    = 4'b0111
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_end,
   input  logic [3:0]            init_cmd,
   input  logic [ADDR_WIDTH-1:0] init_addr,
   input  logic                  ref_rq,
   input  logic                  ref_end,
   input  logic [3:0]            ref_cmd,
   input  logic [ADDR_WIDTH-1:0] ref_addr,
   input  logic                  wr_rq,
   input  logic                  wr_end,
   input  logic [3:0]            wr_cmd,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [1:0]            wr_bank,
   input  logic                  rd_rq,
   input  logic                  rd_end,
   input  logic [3:0]            rd_cmd,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [1:0]            rd_bank,
   output logic                  ref_en,
   output logic                  wr_en,
   output logic                  rd_en,
   output logic [3:0]            sdram_cmd,
   output logic [ADDR_WIDTH-1:0] sdram_addr,
   output logic [1:0]            sdram_bank,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t          state, state_nxt;
   logic            last_rd;
   logic [WD_W-1:0] wd;
   logic            wd_hit;
   logic            tmo;
   logic            in_grant;

   // wd counts cycles already spent in the grant state, so the hit lands on cycle TIMEOUT
   assign wd_hit   = (wd == WD_W'(TIMEOUT - 1));
   assign in_grant = (state == AREF) || (state == WRITE) || (state == READ);

   always_comb begin
      state_nxt = state;
      tmo       = 1'b0;
      case (state)
         INIT:  if (init_end) state_nxt = ARBIT;
         ARBIT: begin
            if (ref_rq)                 state_nxt = AREF;
            else if (wr_rq && rd_rq)    state_nxt = last_rd ? WRITE : READ;
            else if (wr_rq)             state_nxt = WRITE;
            else if (rd_rq)             state_nxt = READ;
         end
         AREF: begin
            if (ref_end)     state_nxt = ARBIT;
            else if (wd_hit) begin state_nxt = ARBIT; tmo = 1'b1; end
         end
         WRITE: begin
            if (wr_end)      state_nxt = ARBIT;
            else if (wd_hit) begin state_nxt = ARBIT; tmo = 1'b1; end
         end
         READ: begin
            if (rd_end)      state_nxt = ARBIT;
            else if (wd_hit) begin state_nxt = ARBIT; tmo = 1'b1; end
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= INIT;
         last_rd <= 1'b1;
         wd      <= '0;
         ref_en  <= 1'b0;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         err     <= 1'b0;
      end else begin
         state  <= state_nxt;
         ref_en <= (state == ARBIT) && (state_nxt == AREF);
         wr_en  <= (state == ARBIT) && (state_nxt == WRITE);
         rd_en  <= (state == ARBIT) && (state_nxt == READ);
         if (state == ARBIT && state_nxt == WRITE)     last_rd <= 1'b0;
         else if (state == ARBIT && state_nxt == READ) last_rd <= 1'b1;
         if (state_nxt != state || !in_grant) wd <= '0;
         else                                 wd <= wd + WD_W'(1);
         if (tmo) err <= 1'b1;
      end
   end

   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_addr = '0;
      sdram_bank = 2'b00;
      case (state)
         INIT:  begin sdram_cmd = init_cmd; sdram_addr = init_addr; end
         AREF:  begin sdram_cmd = ref_cmd;  sdram_addr = ref_addr;  end
         WRITE: begin sdram_cmd = wr_cmd;   sdram_addr = wr_addr; sdram_bank = wr_bank; end
         READ:  begin sdram_cmd = rd_cmd;   sdram_addr = rd_addr; sdram_bank = rd_bank; end
         default: ;
      endcase
   end

   assign busy = (state != ARBIT);

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - randomized and directed check of sdram_arbiter against a cycle model
module tb_sdram_arbiter;

   localparam int         AW  = 12;
   localparam int         TMO = 15;
   localparam logic [3:0] NOP = 4'b0111;
   localparam int S_INIT = 0, S_ARBIT = 1, S_AREF = 2, S_WRITE = 3, S_READ = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0;
   logic          init_end = 1'b0;
   logic [3:0]    init_cmd = 4'h1;
   logic [AW-1:0] init_addr = 12'h111;
   logic          ref_rq = 1'b0, ref_end = 1'b0;
   logic [3:0]    ref_cmd = 4'h2;
   logic [AW-1:0] ref_addr = 12'h222;
   logic          wr_rq = 1'b0, wr_end = 1'b0;
   logic [3:0]    wr_cmd = 4'h3;
   logic [AW-1:0] wr_addr = 12'h333;
   logic [1:0]    wr_bank = 2'd1;
   logic          rd_rq = 1'b0, rd_end = 1'b0;
   logic [3:0]    rd_cmd = 4'h4;
   logic [AW-1:0] rd_addr = 12'h444;
   logic [1:0]    rd_bank = 2'd3;
   logic          ref_en, wr_en, rd_en, busy, err;
   logic [3:0]    sdram_cmd;
   logic [AW-1:0] sdram_addr;
   logic [1:0]    sdram_bank;

   sdram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .CMD_NOP(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
      .ref_rq(ref_rq), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
      .wr_rq(wr_rq), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
      .rd_rq(rd_rq), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
      .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
      .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
      .busy(busy), .err(err)
   );

   int total = 0;
   int bad   = 0;

   // reference model: who holds the bus, for how many cycles, who won the last W/R contest
   int m_st      = S_INIT;
   int m_held    = 0;
   bit m_last_wr = 1'b0;
   bit m_err     = 1'b0;

   int glog[$];
   bit s_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = S_INIT; m_held = 0; m_last_wr = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step();
      int nst;
      bit own_end;
      nst = m_st;
      case (m_st)
         S_INIT:  if (init_end) nst = S_ARBIT;
         S_ARBIT: begin
            if (ref_rq)              nst = S_AREF;
            else if (wr_rq && rd_rq) nst = m_last_wr ? S_READ : S_WRITE;
            else if (wr_rq)          nst = S_WRITE;
            else if (rd_rq)          nst = S_READ;
            if (nst == S_WRITE) m_last_wr = 1'b1;
            if (nst == S_READ)  m_last_wr = 1'b0;
         end
         default: begin
            own_end = (m_st == S_AREF) ? ref_end : (m_st == S_WRITE) ? wr_end : rd_end;
            if (own_end) nst = S_ARBIT;
            else if (m_held >= TMO) begin nst = S_ARBIT; m_err = 1'b1; end
         end
      endcase
      m_held = (nst == m_st) ? m_held + 1 : 1;
      m_st   = nst;
   endtask

   task automatic check_outputs();
      logic [3:0]    e_cmd;
      logic [AW-1:0] e_addr;
      logic [1:0]    e_bank;
      e_cmd = NOP; e_addr = '0; e_bank = 2'd0;
      case (m_st)
         S_INIT:  begin e_cmd = init_cmd; e_addr = init_addr; end
         S_AREF:  begin e_cmd = ref_cmd;  e_addr = ref_addr;  end
         S_WRITE: begin e_cmd = wr_cmd;   e_addr = wr_addr; e_bank = wr_bank; end
         S_READ:  begin e_cmd = rd_cmd;   e_addr = rd_addr; e_bank = rd_bank; end
         default: ;
      endcase
      check("busy", busy, m_st != S_ARBIT);
      check("err", err, m_err);
      check("ref_en", ref_en, m_st == S_AREF && m_held == 1);
      check("wr_en", wr_en, m_st == S_WRITE && m_held == 1);
      check("rd_en", rd_en, m_st == S_READ && m_held == 1);
      check("sdram_cmd", sdram_cmd, e_cmd);
      check("sdram_addr", sdram_addr, e_addr);
      check("sdram_bank", sdram_bank, e_bank);
      if (ref_en === 1'b1) glog.push_back(S_AREF);
      if (wr_en === 1'b1)  glog.push_back(S_WRITE);
      if (rd_en === 1'b1)  glog.push_back(S_READ);
      s_busy = busy;
   endtask

   task automatic cyc();
      if (!rst_n) model_reset();
      @(negedge clk);
      check_outputs();
      if (rst_n) model_step();
      else       model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) cyc();
      rst_n = 1'b1;
   endtask

   task automatic do_init();
      init_end = 1'b1; cyc(); init_end = 1'b0;
   endtask

   initial begin
      int cnt;
      int w;
      int n0;

      do_reset(3);
      ref_rq = 1'b1; wr_rq = 1'b1; rd_rq = 1'b1;
      repeat (4) cyc();
      check("init_ignores_rq", s_busy, 1'b1);
      ref_rq = 1'b0; wr_rq = 1'b0; rd_rq = 1'b0;

      // refresh beats a simultaneous write, write follows once refresh ends
      do_init();
      glog.delete();
      ref_rq = 1'b1; wr_rq = 1'b1; cyc(); ref_rq = 1'b0;
      repeat (3) cyc();
      ref_end = 1'b1; cyc(); ref_end = 1'b0;
      cyc();
      wr_rq = 1'b0;
      repeat (3) cyc();
      wr_end = 1'b1; cyc(); wr_end = 1'b0;
      cyc();
      check("ref_wr_count", glog.size(), 2);
      if (glog.size() == 2) begin
         check("ref_first", glog[0], S_AREF);
         check("wr_second", glog[1], S_WRITE);
      end

      // alternating contest after reset starts with WRITE
      do_reset(2);
      do_init();
      glog.delete();
      wr_rq = 1'b1; rd_rq = 1'b1;
      repeat (4) begin
         n0 = glog.size();
         w = 0;
         while (glog.size() == n0 && w < 10) begin cyc(); w++; end
         if (w >= 10) check("grant_wait", 0, 1);
         repeat (7) cyc();
         wr_end = 1'b1; rd_end = 1'b1; cyc(); wr_end = 1'b0; rd_end = 1'b0;
      end
      wr_rq = 1'b0; rd_rq = 1'b0;
      cyc();
      check("alt_count", glog.size(), 4);
      if (glog.size() == 4) begin
         check("alt0", glog[0], S_WRITE);
         check("alt1", glog[1], S_READ);
         check("alt2", glog[2], S_WRITE);
         check("alt3", glog[3], S_READ);
      end

      // read bus routing; foreign end pulse ignored
      rd_addr = 12'h0A5; rd_bank = 2'd2;
      rd_rq = 1'b1; cyc(); rd_rq = 1'b0;
      cyc();
      check("rd_addr_mux", sdram_addr, 12'h0A5);
      check("rd_bank_mux", sdram_bank, 2'd2);
      wr_end = 1'b1; cyc(); wr_end = 1'b0;
      check("foreign_end", busy, 1'b1);
      rd_end = 1'b1; cyc(); rd_end = 1'b0;
      cyc();

      // watchdog: write never ends
      wr_rq = 1'b1; cyc(); wr_rq = 1'b0;
      cnt = 0;
      repeat (20) begin cyc(); cnt += int'(s_busy); end
      check("tmo_len", cnt, TMO);
      check("tmo_err", err, 1'b1);
      glog.delete();
      rd_rq = 1'b1; cyc(); rd_rq = 1'b0;
      cyc();
      check("rd_after_tmo", (glog.size() == 1) ? glog[0] : -1, S_READ);
      repeat (3) cyc();
      rd_end = 1'b1; cyc(); rd_end = 1'b0;
      cyc();
      check("err_sticky", err, 1'b1);

      // reset mid-write
      wr_rq = 1'b1; cyc(); wr_rq = 1'b0;
      repeat (3) cyc();
      do_reset(3);
      check("rst_err", err, 1'b0);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_cmd", sdram_cmd, init_cmd);
      ref_rq = 1'b1; wr_rq = 1'b1; rd_rq = 1'b1;
      repeat (3) cyc();
      check("rst_no_grant", {ref_en, wr_en, rd_en}, 3'b000);
      ref_rq = 1'b0; wr_rq = 1'b0; rd_rq = 1'b0;
      do_init();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         init_cmd  = 4'($urandom);  init_addr = AW'($urandom);
         ref_cmd   = 4'($urandom);  ref_addr  = AW'($urandom);
         wr_cmd    = 4'($urandom);  wr_addr   = AW'($urandom); wr_bank = 2'($urandom);
         rd_cmd    = 4'($urandom);  rd_addr   = AW'($urandom); rd_bank = 2'($urandom);
         ref_rq    = ($urandom_range(5) == 0);
         wr_rq     = ($urandom_range(1) == 0);
         rd_rq     = ($urandom_range(1) == 0);
         init_end  = (m_st == S_INIT) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 0);
         ref_end   = (m_st == S_AREF)  ? ($urandom_range(7) == 0) : ($urandom_range(15) == 0);
         wr_end    = (m_st == S_WRITE) ? ($urandom_range(7) == 0) : ($urandom_range(15) == 0);
         rd_end    = (m_st == S_READ)  ? ($urandom_range(7) == 0) : ($urandom_range(15) == 0);
         rst_n     = ($urandom_range(399) != 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
